vga_sync_gen: RTL and testbench

//  Timing core of the VGA driver, directly downstream of the clock/reset/enable source.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 27 ++
 rtl/vga_sync_gen.sv | 96 +++++++++
 tb/tb_vga_sync_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, counter width, horizontal phase type and sync-window helper
// for the VGA timing core.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam bit SYNC_POL_DEF = 1'b0;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    ACTIVE,
    FP,
    SYNC,
    BP
  } hphase_t;

  // True while pos lies in [start, start+width).
  function automatic logic in_window(input logic [CNT_W-1:0] pos, input int start,
                                     input int width);
    return (int'(pos) >= start) && (int'(pos) < start + width);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Mod-N position counter with enable and synchronous reset; wrap flags the terminal
// count so a downstream counter can be chained off it.
module vga_axis_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Explicit compare against N-1 so non-power-of-two totals wrap correctly.
  assign wrap = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing core: chained h/v position counters, horizontal phase FSM and registered
// sync, visibility, coordinate and strobe outputs, all advancing only while en=1.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_end,
  output logic             frame_start
);

  localparam int H_SPAN = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_SPAN = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] FP_LAST   = CNT_W'(H_ACTIVE + H_FP - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_VIS     = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             v_en;
  hphase_t          phase;
  logic             at_origin;

  assign v_en = en && h_wrap;

  vga_axis_counter #(.N(H_SPAN), .W(CNT_W)) u_h_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  vga_axis_counter #(.N(V_SPAN), .W(CNT_W)) u_v_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (v_en),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  // phase always names the region h_cnt is in; at_origin marks (0,0) as next to emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= ACTIVE;
      at_origin   <= 1'b1;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      hsync       <= (phase == SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= in_window(v_cnt, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on    <= (phase == ACTIVE) && (v_cnt < V_VIS);
      line_end    <= h_wrap;
      frame_start <= at_origin;
      at_origin   <= h_wrap && v_wrap;
      case (phase)
        ACTIVE:  if (h_cnt == ACT_LAST)  phase <= FP;
        FP:      if (h_cnt == FP_LAST)   phase <= SYNC;
        SYNC:    if (h_cnt == SYNC_LAST) phase <= BP;
        BP:      if (h_wrap)             phase <= ACTIVE;
        default: phase <= ACTIVE;
      endcase
    end else begin
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a reduced active-high-sync
// instance, both checked every cycle against a position-based reference model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       le;
    logic       fs;
  } outs_t;

  typedef struct packed {
    logic  r;
    logic  e;
    outs_t exp;
  } vec_t;

  localparam int DHA = 640, DHF = 16, DHS = 96, DHT = 800;
  localparam int DVA = 480, DVF = 10, DVS = 2, DVT = 525;
  localparam int SHA = 64, SHF = 4, SHS = 8, SHB = 6, SHT = 82;
  localparam int SVA = 20, SVF = 3, SVS = 2, SVB = 4, SVT = 29;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  logic       d_hs, d_vs, d_vo, d_le, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_vo, s_le, s_fs;
  logic [9:0] s_x, s_y;
  outs_t      act_d, act_s;

  assign act_d = {d_x, d_y, d_vo, d_hs, d_vs, d_le, d_fs};
  assign act_s = {s_x, s_y, s_vo, s_hs, s_vs, s_le, s_fs};

  always #5 clk = ~clk;

  vga_sync_gen dut_d (
    .clk(clk), .rst(rst), .en(en),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
    .pixel_x(d_x), .pixel_y(d_y),
    .line_end(d_le), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
    .pixel_x(s_x), .pixel_y(s_y),
    .line_end(s_le), .frame_start(s_fs)
  );

  int n_checks = 0;
  int n_err    = 0;
  int dx = 0, dy = 0, sx = 0, sy = 0;
  outs_t ed, es;

  function automatic outs_t decode(int x, int y, int ha, int hf, int hsw, int ht,
                                   int va, int vf, int vsw, bit pol);
    outs_t o;
    o.x  = 10'(x);
    o.y  = 10'(y);
    o.vo = (x < ha) && (y < va);
    o.hs = (x >= ha + hf && x < ha + hf + hsw) ? pol : ~pol;
    o.vs = (y >= va + vf && y < va + vf + vsw) ? pol : ~pol;
    o.le = (x == ht - 1);
    o.fs = (x == 0) && (y == 0);
    return o;
  endfunction

  function automatic outs_t reset_outs(bit pol);
    outs_t o;
    o    = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    return o;
  endfunction

  function automatic vec_t mk(logic r, logic e, int x, int y, logic vo, logic hs,
                              logic vs, logic le, logic fs);
    vec_t v;
    v.r   = r;
    v.e   = e;
    v.exp = {10'(x), 10'(y), vo, hs, vs, le, fs};
    return v;
  endfunction

  task automatic model_step(input logic r, input logic e);
    if (r) begin
      dx = 0; dy = 0; sx = 0; sy = 0;
      ed = reset_outs(1'b0);
      es = reset_outs(1'b1);
    end else if (e) begin
      ed = decode(dx, dy, DHA, DHF, DHS, DHT, DVA, DVF, DVS, 1'b0);
      es = decode(sx, sy, SHA, SHF, SHS, SHT, SVA, SVF, SVS, 1'b1);
      dx++;
      if (dx == DHT) begin dx = 0; dy = (dy == DVT - 1) ? 0 : dy + 1; end
      sx++;
      if (sx == SHT) begin sx = 0; sy = (sy == SVT - 1) ? 0 : sy + 1; end
    end else begin
      ed.le = 1'b0; ed.fs = 1'b0;
      es.le = 1'b0; es.fs = 1'b0;
    end
  endtask

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got x=%0d y=%0d vo,hs,vs,le,fs=%b%b%b%b%b want x=%0d y=%0d vo,hs,vs,le,fs=%b%b%b%b%b",
               name, $time, act.x, act.y, act.vo, act.hs, act.vs, act.le, act.fs,
               exp.x, exp.y, exp.vo, exp.hs, exp.vs, exp.le, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    #1;
    model_step(r, e);
    check("model_default", act_d, ed);
    check("model_small", act_s, es);
  endtask

  vec_t vq[$];

  initial begin
    int hs_low, hs_first, hs_last, vo_off, le_cnt, le_bad, dfs_cnt, dymax;
    int sfs_cnt, svs_min, svs_max, symax, found;

    // Directed vectors against the default-timing instance.
    for (int i = 0; i < 5; i++) vq.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 1, 1, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 2, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 2, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 2, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 3, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 1, 1, 1, 0, 0));
    foreach (vq[i]) begin
      tick(vq[i].r, vq[i].e);
      check($sformatf("vec%0d", i), act_d, vq[i].exp);
    end

    // Long enabled run: line timing on default, frame timing on the small instance.
    hs_low = 0; hs_first = -1; hs_last = -1; vo_off = -1; le_cnt = 0; le_bad = 0;
    dfs_cnt = 0; dymax = 0; sfs_cnt = 0; svs_min = 1000; svs_max = -1; symax = 0;
    tick(1, 1);
    for (int i = 0; i < 5000; i++) begin
      tick(0, 1);
      if (d_y == 10'd0) begin
        if (!d_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(d_x);
          hs_last = int'(d_x);
        end
        if (!d_vo && vo_off < 0) vo_off = int'(d_x);
      end
      if (d_le) begin le_cnt++; if (d_x != 10'd799) le_bad++; end
      if (d_fs) dfs_cnt++;
      if (int'(d_y) > dymax) dymax = int'(d_y);
      if (s_fs) sfs_cnt++;
      if (s_vs) begin
        if (int'(s_y) < svs_min) svs_min = int'(s_y);
        if (int'(s_y) > svs_max) svs_max = int'(s_y);
      end
      if (int'(s_y) > symax) symax = int'(s_y);
    end
    check_int("hsync_low_cycles", hs_low, 96);
    check_int("hsync_first_x", hs_first, 656);
    check_int("hsync_last_x", hs_last, 751);
    check_int("video_off_x", vo_off, 640);
    check_int("line_end_count", le_cnt, 6);
    check_int("line_end_bad_x", le_bad, 0);
    check_int("default_frame_starts", dfs_cnt, 1);
    check_int("default_y_max", dymax, 6);
    check_int("small_frame_starts", sfs_cnt, 3);
    check_int("small_vsync_y_min", svs_min, SVA + SVF);
    check_int("small_vsync_y_max", svs_max, SVA + SVF + SVS - 1);
    check_int("small_y_max", symax, SVT - 1);

    // Freeze at x=655 for 7 cycles, then resume onto the hsync edge.
    tick(1, 1);
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      tick(0, 1);
      if (d_x == 10'd655) found = 1;
    end
    check_int("reach_x655", found, 1);
    for (int i = 0; i < 7; i++) begin
      tick(0, 0);
      check_int("freeze_no_pulse", int'(d_le) + int'(d_fs) + int'(s_le) + int'(s_fs), 0);
    end
    check_int("freeze_x", int'(d_x), 655);
    check_int("freeze_hs", int'(d_hs), 1);
    tick(0, 1);
    check_int("resume_x", int'(d_x), 656);
    check_int("resume_hs", int'(d_hs), 0);

    // Mid-frame reset on the small instance, then restart.
    tick(1, 1);
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      tick(0, 1);
      if (s_x == 10'd30 && s_y == 10'd10) found = 1;
    end
    check_int("reach_small_30_10", found, 1);
    tick(1, 1);
    check_int("midrst_small_xy", int'(s_x) + int'(s_y), 0);
    check_int("midrst_small_syncs", int'(s_hs) + int'(s_vs), 0);
    check_int("midrst_default_syncs", int'(d_hs) + int'(d_vs), 2);
    tick(0, 1);
    check_int("restart_fs", int'(d_fs) + int'(s_fs), 2);
    check_int("restart_vo", int'(d_vo) + int'(s_vo), 2);

    // Mid-line reset on the default instance at x=300.
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      tick(0, 1);
      if (d_x == 10'd300) found = 1;
    end
    check_int("reach_x300", found, 1);
    tick(1, 1);
    check_int("midrst_default_x", int'(d_x), 0);

    // Randomised enable with occasional resets.
    for (int i = 0; i < 6000; i++) begin
      tick(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
